// File: rtl/key_if.sv
// Pin-side and conditioned-side signals of the push-button conditioner.
// master = conditioner, slave = pin driver / consumer of the conditioned keys.
interface key_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic              sys_reset;

    modport master (
        input  key_n,
        output key_level, key_press, key_release, sys_reset
    );

    modport slave (
        output key_n,
        input  key_level, key_press, key_release, sys_reset
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop sync, counter debounce, press/release pulses,
// plus a stretched system reset driven by one selected key.
module key_conditioner #(
    parameter int unsigned N_KEYS      = 4,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DEBOUNCE    = 270000,
    parameter int unsigned RST_KEY     = 0,
    parameter int unsigned RST_STRETCH = 16
) (
    input  logic clk,
    input  logic reset,
    key_if.master kif
);
    localparam int unsigned       STR_W    = 5;
    localparam logic [CNT_W-1:0]  DB_MAX   = CNT_W'(DEBOUNCE - 1);
    localparam logic [STR_W-1:0]  STR_LOAD = STR_W'(RST_STRETCH);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    logic [N_KEYS-1:0] s1_q, s2_q;
    logic [N_KEYS-1:0] sample;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];

    state_t            state_q, state_d;
    logic [STR_W-1:0]  stretch_q, stretch_d;
    logic              sys_q, sys_d;
    logic              rst_lvl;

    // Two-flop synchroniser; idle level is released (1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= kif.key_n;
            s2_q <= s1_q;
        end
    end

    assign sample = ~s2_q;

    // Debounce: a new level is accepted after DEBOUNCE consecutive differing samples.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sample[i] != level_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    level_d[i]   = sample[i];
                    press_d[i]   = sample[i];
                    release_d[i] = ~sample[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Using the next debounced level lets sys_reset rise in the same cycle as key_level.
    assign rst_lvl = level_d[RST_KEY];

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        sys_d     = sys_q;
        case (state_q)
            ST_ASSERT: begin
                if (rst_lvl) begin
                    state_d   = ST_HOLD;
                    stretch_d = STR_LOAD;
                    sys_d     = 1'b1;
                end else if (stretch_q <= STR_W'(1)) begin
                    state_d   = ST_RUN;
                    stretch_d = '0;
                    sys_d     = 1'b0;
                end else begin
                    stretch_d = stretch_q - STR_W'(1);
                    sys_d     = 1'b1;
                end
            end
            ST_HOLD: begin
                stretch_d = STR_LOAD;
                sys_d     = 1'b1;
                if (!rst_lvl) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_RUN: begin
                if (rst_lvl) begin
                    state_d   = ST_HOLD;
                    stretch_d = STR_LOAD;
                    sys_d     = 1'b1;
                end else begin
                    sys_d     = 1'b0;
                end
            end
            default: begin
                state_d   = ST_ASSERT;
                stretch_d = STR_LOAD;
                sys_d     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ASSERT;
            stretch_q <= STR_LOAD;
            sys_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
            sys_q     <= sys_d;
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.sys_reset   = sys_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE=4, RST_STRETCH=8, 4 keys, reset key 0).
module tb_key_conditioner;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    key_if #(.N_KEYS(4)) kif ();

    key_conditioner #(
        .N_KEYS(4), .CNT_W(4), .DEBOUNCE(4), .RST_KEY(0), .RST_STRETCH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kif  (kif.master)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; leaves time 1 unit after the last rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        kif.key_n = 4'hF;
        #2 reset = 1'b1;
        tick(3);
        checks++;
        if ({kif.key_level, kif.key_press, kif.key_release} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h required %h",
                     {kif.key_level, kif.key_press, kif.key_release}, 12'h000);
        end
        checks++;
        if (kif.sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_sys_during: got %b required 1", kif.sys_reset);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (kif.sys_reset !== 1'b1) begin
                failures++;
                $display("FAIL reset_stretch_c%0d: got %b required 1", i, kif.sys_reset);
            end
            tick(1);
        end
        checks++;
        if (kif.sys_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got %b required 0", kif.sys_reset);
        end
    endtask

    task automatic test_press_release;
        kif.key_n[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            checks++;
            if (kif.key_level[1] !== 1'b0 || kif.key_press !== 4'h0) begin
                failures++;
                $display("FAIL press_early_t%0d: got level=%b press=%b required level=0 press=0000",
                         i, kif.key_level[1], kif.key_press);
            end
        end
        tick(1);
        checks++;
        if (kif.key_level !== 4'b0010 || kif.key_press !== 4'b0010 || kif.key_release !== 4'h0) begin
            failures++;
            $display("FAIL press_edge: got level=%b press=%b release=%b required 0010 0010 0000",
                     kif.key_level, kif.key_press, kif.key_release);
        end
        tick(1);
        checks++;
        if (kif.key_level !== 4'b0010 || kif.key_press !== 4'h0) begin
            failures++;
            $display("FAIL press_pulse_end: got level=%b press=%b required 0010 0000",
                     kif.key_level, kif.key_press);
        end
        kif.key_n[1] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            checks++;
            if (kif.key_level[1] !== 1'b1 || kif.key_release !== 4'h0) begin
                failures++;
                $display("FAIL release_early_t%0d: got level=%b release=%b required level=1 release=0000",
                         i, kif.key_level[1], kif.key_release);
            end
        end
        tick(1);
        checks++;
        if (kif.key_level !== 4'h0 || kif.key_release !== 4'b0010 || kif.key_press !== 4'h0) begin
            failures++;
            $display("FAIL release_edge: got level=%b press=%b release=%b required 0000 0000 0010",
                     kif.key_level, kif.key_press, kif.key_release);
        end
        tick(1);
        checks++;
        if (kif.key_release !== 4'h0) begin
            failures++;
            $display("FAIL release_pulse_end: got %b required 0000", kif.key_release);
        end
    endtask

    task automatic test_glitch;
        kif.key_n[2] = 1'b0;
        tick(3);
        kif.key_n[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if ({kif.key_level, kif.key_press, kif.key_release} !== 12'h000) begin
                failures++;
                $display("FAIL glitch_t%0d: got %h required 000", i,
                         {kif.key_level, kif.key_press, kif.key_release});
            end
        end
    endtask

    task automatic test_bounce;
        for (int r = 0; r < 5; r++) begin
            kif.key_n[2] = 1'b0;
            tick(2);
            kif.key_n[2] = 1'b1;
            tick(2);
            checks++;
            if (kif.key_level[2] !== 1'b0 || kif.key_press !== 4'h0) begin
                failures++;
                $display("FAIL bounce_r%0d: got level=%b press=%b required 0 0000",
                         r, kif.key_level[2], kif.key_press);
            end
        end
        kif.key_n[2] = 1'b0;
        tick(5);
        checks++;
        if (kif.key_level[2] !== 1'b0 || kif.key_press !== 4'h0) begin
            failures++;
            $display("FAIL bounce_settle_early: got level=%b press=%b required 0 0000",
                     kif.key_level[2], kif.key_press);
        end
        tick(1);
        checks++;
        if (kif.key_level !== 4'b0100 || kif.key_press !== 4'b0100) begin
            failures++;
            $display("FAIL bounce_press: got level=%b press=%b required 0100 0100",
                     kif.key_level, kif.key_press);
        end
        tick(1);
        checks++;
        if (kif.key_press !== 4'h0) begin
            failures++;
            $display("FAIL bounce_single_pulse: got %b required 0000", kif.key_press);
        end
        kif.key_n[2] = 1'b1;
        tick(8);
        checks++;
        if (kif.key_level !== 4'h0) begin
            failures++;
            $display("FAIL bounce_release: got %b required 0000", kif.key_level);
        end
    endtask

    task automatic test_simultaneous;
        kif.key_n = 4'b0101;
        tick(5);
        checks++;
        if (kif.key_level !== 4'h0) begin
            failures++;
            $display("FAIL simul_early: got %b required 0000", kif.key_level);
        end
        tick(1);
        checks++;
        if (kif.key_level !== 4'b1010 || kif.key_press !== 4'b1010) begin
            failures++;
            $display("FAIL simul_press: got level=%b press=%b required 1010 1010",
                     kif.key_level, kif.key_press);
        end
        kif.key_n = 4'hF;
        tick(6);
        checks++;
        if (kif.key_level !== 4'h0 || kif.key_release !== 4'b1010 || kif.key_press !== 4'h0) begin
            failures++;
            $display("FAIL simul_release: got level=%b press=%b release=%b required 0000 0000 1010",
                     kif.key_level, kif.key_press, kif.key_release);
        end
        tick(1);
    endtask

    task automatic test_sys_reset;
        checks++;
        if (kif.sys_reset !== 1'b0) begin
            failures++;
            $display("FAIL sys_idle: got %b required 0", kif.sys_reset);
        end
        kif.key_n[0] = 1'b0;
        tick(5);
        checks++;
        if (kif.sys_reset !== 1'b0 || kif.key_level[0] !== 1'b0) begin
            failures++;
            $display("FAIL sys_before_press: got sys=%b level=%b required 0 0",
                     kif.sys_reset, kif.key_level[0]);
        end
        tick(1);
        checks++;
        if (kif.sys_reset !== 1'b1 || kif.key_level !== 4'b0001 || kif.key_press !== 4'b0001) begin
            failures++;
            $display("FAIL sys_rise: got sys=%b level=%b press=%b required 1 0001 0001",
                     kif.sys_reset, kif.key_level, kif.key_press);
        end
        for (int i = 0; i < 14; i++) begin
            tick(1);
            checks++;
            if (kif.sys_reset !== 1'b1 || kif.key_level[0] !== 1'b1) begin
                failures++;
                $display("FAIL sys_hold_t%0d: got sys=%b level=%b required 1 1",
                         i, kif.sys_reset, kif.key_level[0]);
            end
        end
        kif.key_n[0] = 1'b1;
        tick(6);
        checks++;
        if (kif.sys_reset !== 1'b1 || kif.key_level[0] !== 1'b0 || kif.key_release !== 4'b0001) begin
            failures++;
            $display("FAIL sys_key_fall: got sys=%b level=%b release=%b required 1 0 0001",
                     kif.sys_reset, kif.key_level[0], kif.key_release);
        end
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            checks++;
            if (kif.sys_reset !== 1'b1) begin
                failures++;
                $display("FAIL sys_stretch_t%0d: got %b required 1", i, kif.sys_reset);
            end
        end
        tick(1);
        checks++;
        if (kif.sys_reset !== 1'b0) begin
            failures++;
            $display("FAIL sys_fall: got %b required 0", kif.sys_reset);
        end

        // Press, release, then re-press before the stretch runs out.
        kif.key_n[0] = 1'b0;
        tick(9);
        kif.key_n[0] = 1'b1;
        tick(6);
        checks++;
        if (kif.key_level[0] !== 1'b0 || kif.sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL repress_fall: got level=%b sys=%b required 0 1",
                     kif.key_level[0], kif.sys_reset);
        end
        kif.key_n[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            checks++;
            if (kif.sys_reset !== 1'b1) begin
                failures++;
                $display("FAIL repress_hold_t%0d: got %b required 1", i, kif.sys_reset);
            end
        end
        checks++;
        if (kif.key_level[0] !== 1'b1) begin
            failures++;
            $display("FAIL repress_level: got %b required 1", kif.key_level[0]);
        end

        // Asynchronous reset mid-press, away from any clock edge.
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({kif.key_level, kif.key_press, kif.key_release, kif.sys_reset} !== 13'h0001) begin
            failures++;
            $display("FAIL async_reset: got %h required 0001",
                     {kif.key_level, kif.key_press, kif.key_release, kif.sys_reset});
        end
        tick(2);
        checks++;
        if (kif.key_level !== 4'h0 || kif.sys_reset !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_held: got level=%b sys=%b required 0000 1",
                     kif.key_level, kif.sys_reset);
        end
        kif.key_n = 4'hF;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (kif.sys_reset !== 1'b1) begin
                failures++;
                $display("FAIL async_stretch_c%0d: got %b required 1", i, kif.sys_reset);
            end
            tick(1);
        end
        checks++;
        if (kif.sys_reset !== 1'b0 || kif.key_level !== 4'h0) begin
            failures++;
            $display("FAIL async_recover: got sys=%b level=%b required 0 0000",
                     kif.sys_reset, kif.key_level);
        end
    endtask

    initial begin
        kif.key_n = 4'hF;
        test_reset();
        test_press_release();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_sys_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
